// File: rtl/instruction_fetch_pkg.sv
// Shared widths, constants, state encoding and skid payload for the fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_VECTOR    = 32'h0000_0000;
  localparam logic [DATA_W-1:0] NOP_WORD        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] INST_ADDR_STEP  = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_FULL  = 2'd2,
    FETCH_FLUSH = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_skid_register.sv
// One-entry holding register for a fetched word that arrived while ID was stalled.
module instruction_fetch_skid_register
  import instruction_fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid
);

  // Clear wins over load; the entry is zeroed so a stale word never leaks out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, runs the imem request/ready handshake and feeds IF/ID.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_enable,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_request,
  output logic [ADDR_W-1:0] imem_address,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_data,
  output logic [ADDR_W-1:0] if_program_counter,
  output logic [DATA_W-1:0] if_instruction,
  output logic              if_valid
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] target_c;
  logic [ADDR_W-1:0] next_pc_c;
  logic              skid_load_c;
  logic              skid_clear_c;
  logic              skid_valid;
  fetch_entry_t      skid_entry;
  fetch_entry_t      capture_c;

  assign target_c     = branch_target & ADDR_ALIGN_MASK;
  assign next_pc_c    = fetch_pc + INST_ADDR_STEP;
  assign capture_c    = '{address: imem_address, word: imem_data};
  assign skid_load_c  = (state == FETCH_WAIT) && imem_ready && stall && !branch_enable;
  assign skid_clear_c = (state == FETCH_FULL) && (branch_enable || !stall);

  instruction_fetch_skid_register u_skid (
    .clock      (clock),
    .reset      (reset),
    .load       (skid_load_c),
    .clear      (skid_clear_c),
    .load_entry (capture_c),
    .entry      (skid_entry),
    .valid      (skid_valid)
  );

  // Fetch FSM, PC, request and IF/ID output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= FETCH_IDLE;
      fetch_pc           <= RESET_VECTOR;
      imem_request       <= 1'b0;
      imem_address       <= RESET_VECTOR;
      if_program_counter <= '0;
      if_instruction     <= NOP_WORD;
      if_valid           <= 1'b0;
    end else begin
      // Any unstalled cycle without a delivery presents a bubble.
      if (!stall) begin
        if_valid       <= 1'b0;
        if_instruction <= NOP_WORD;
      end
      case (state)
        FETCH_IDLE: begin
          if (branch_enable) fetch_pc <= target_c;
          if (!stall) begin
            imem_request <= 1'b1;
            imem_address <= branch_enable ? target_c : fetch_pc;
            state        <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (branch_enable) begin
            fetch_pc <= target_c;
            if (imem_ready) imem_address <= target_c;
            else            state        <= FETCH_FLUSH;
          end else if (imem_ready) begin
            if (stall) begin
              imem_request <= 1'b0;
              state        <= FETCH_FULL;
            end else begin
              if_program_counter <= imem_address;
              if_instruction     <= imem_data;
              if_valid           <= 1'b1;
              fetch_pc           <= next_pc_c;
              imem_address       <= next_pc_c;
            end
          end
        end
        FETCH_FLUSH: begin
          if (branch_enable) fetch_pc <= target_c;
          if (imem_ready) begin
            imem_address <= branch_enable ? target_c : fetch_pc;
            state        <= FETCH_WAIT;
          end
        end
        FETCH_FULL: begin
          if (branch_enable) begin
            fetch_pc     <= target_c;
            imem_request <= 1'b1;
            imem_address <= target_c;
            state        <= FETCH_WAIT;
          end else if (!stall) begin
            if_program_counter <= skid_entry.address;
            if_instruction     <= skid_entry.word;
            if_valid           <= skid_valid;
            fetch_pc           <= next_pc_c;
            imem_request       <= 1'b1;
            imem_address       <= next_pc_c;
            state              <= FETCH_WAIT;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: wait-state memory model plus PC scoreboard.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_enable = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] if_program_counter;
  logic [31:0] if_instruction;
  logic        if_valid;

  instruction_fetch dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .branch_enable      (branch_enable),
    .branch_target      (branch_target),
    .imem_request       (imem_request),
    .imem_address       (imem_address),
    .imem_ready         (imem_ready),
    .imem_data          (imem_data),
    .if_program_counter (if_program_counter),
    .if_instruction     (if_instruction),
    .if_valid           (if_valid)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          mon_on = 1'b0;
  logic        stall_q = 1'b0;
  int unsigned cyc = 0;
  int unsigned first_cyc, last_cyc, n_pops, addr4_cnt;
  int unsigned mem_wait = 0;
  int unsigned mem_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory: answers a held request after mem_wait idle cycles; driven just after the edge.
  initial begin
    imem_ready = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clock); #1;
      if (!reset || !imem_request) begin
        imem_ready = 1'b0; imem_data = 32'hDEAD_BEEF; mem_cnt = 0;
      end else if (mem_cnt == mem_wait) begin
        imem_ready = 1'b1; imem_data = mem_word(imem_address); mem_cnt = 0;
      end else begin
        imem_ready = 1'b0; imem_data = 32'hDEAD_BEEF; mem_cnt++;
      end
    end
  end

  // Edge bookkeeping: stall seen by the DUT and cycles since reset release.
  initial forever begin
    @(posedge clock);
    stall_q = stall;
    if (!reset) cyc = 0; else cyc++;
  end

  // Monitor: a fresh delivery is if_valid after an unstalled edge.
  initial forever begin
    @(negedge clock);
    if (mon_on) begin
      if (imem_request && imem_address == 32'h4) addr4_cnt++;
      if (!if_valid) check32("bubble_nop", if_instruction, NOP_WORD);
      else if (!stall_q) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_delivery actual=%h expected=none", if_program_counter);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check32("deliver_pc", if_program_counter, e);
          check32("deliver_word", if_instruction, mem_word(e));
          if (n_pops == 0) first_cyc = cyc + 1;
          last_cyc = cyc + 1;
          n_pops++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic reset_dut(input int unsigned w);
    @(negedge clock);
    mon_on = 1'b0; reset = 1'b0; stall = 1'b0; branch_enable = 1'b0; branch_target = 32'h0;
    mem_wait = w; exp_q.delete();
    repeat (2) @(negedge clock);
    n_pops = 0; first_cyc = 0; last_cyc = 0; addr4_cnt = 0;
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    @(posedge clock);
    while (exp_q.size() != 0 && n < 300) begin @(posedge clock); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
    mon_on = 1'b0;
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string name);
    int unsigned n = 0;
    do begin @(negedge clock); n++; end
    while (!(if_valid && if_program_counter == pc) && n < 100);
    checks++;
    if (!(if_valid && if_program_counter == pc)) begin
      errors++;
      $display("FAIL %s_timeout actual=%h expected=%h", name, if_program_counter, pc);
    end
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    int unsigned n = 0;
    do begin @(negedge clock); n++; end
    while (!(imem_request && imem_address == a && !imem_ready) && n < 100);
    checks++;
    if (!(imem_request && imem_address == a && !imem_ready)) begin
      errors++;
      $display("FAIL %s_timeout actual=%h expected=%h", name, imem_address, a);
    end
  endtask

  typedef struct {
    int unsigned wait_cycles;
    int unsigned n_items;
    int unsigned first_lat;
    int unsigned last_lat;
    int unsigned addr4_hold;
  } stream_vec_t;

  stream_vec_t vecs[4];

  initial begin
    // latency of item i = 3 + w + i*(w+1), counted in edges from the first released edge
    vecs[0] = '{0, 6, 3,  8, 1};
    vecs[1] = '{1, 4, 4, 10, 2};
    vecs[2] = '{2, 4, 5, 14, 3};
    vecs[3] = '{3, 3, 6, 14, 4};

    for (int v = 0; v < 4; v++) begin
      reset_dut(vecs[v].wait_cycles);
      check32("rst_request", 32'(imem_request), 32'h0);
      check32("rst_address", imem_address, RESET_VECTOR);
      check32("rst_pc", if_program_counter, 32'h0);
      check32("rst_instr", if_instruction, NOP_WORD);
      check32("rst_valid", 32'(if_valid), 32'h0);
      push_run(32'h0, int'(vecs[v].n_items));
      reset = 1'b1; mon_on = 1'b1;
      @(negedge clock);
      check32("first_request", 32'(imem_request), 32'h1);
      drain("stream");
      check32("first_latency", first_cyc, vecs[v].first_lat);
      check32("last_latency", last_cyc, vecs[v].last_lat);
      check32("addr4_hold", addr4_cnt, vecs[v].addr4_hold);
    end

    // Stall on a delivery cycle for three cycles.
    reset_dut(0);
    push_run(32'h0, 5);
    reset = 1'b1; mon_on = 1'b1;
    wait_pc(32'h8, "stall_arm");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check32("stall_pc", if_program_counter, 32'h8);
      check32("stall_valid", 32'(if_valid), 32'h1);
      check32("stall_instr", if_instruction, mem_word(32'h8));
      check32("stall_request", 32'(imem_request), 32'h0);
    end
    stall = 1'b0;
    @(negedge clock);
    check32("unstall_address", imem_address, 32'h10);
    drain("stall");

    // Branch while a request at 0x20 waits on memory.
    reset_dut(2);
    push_run(32'h0, 8);
    push_run(32'h100, 2);
    reset = 1'b1; mon_on = 1'b1;
    wait_req(32'h20, "br_wait_arm");
    branch_enable = 1'b1; branch_target = 32'h100;
    @(negedge clock);
    branch_enable = 1'b0;
    check32("flush_hold_addr", imem_address, 32'h20);
    check32("flush_bubble", 32'(if_valid), 32'h0);
    for (int i = 0; i < 20 && imem_address == 32'h20; i++) @(negedge clock);
    check32("flush_next_addr", imem_address, 32'h100);
    drain("branch_wait");

    // Branch to an unaligned target while stalled in FULL.
    reset_dut(0);
    push_run(32'h0, 3);
    push_run(32'h200, 2);
    reset = 1'b1; mon_on = 1'b1;
    wait_pc(32'h8, "full_arm");
    stall = 1'b1;
    @(negedge clock);
    branch_enable = 1'b1; branch_target = 32'h203;
    @(negedge clock);
    branch_enable = 1'b0;
    check32("full_br_request", 32'(imem_request), 32'h1);
    check32("full_br_address", imem_address, 32'h200);
    check32("full_br_pc_hold", if_program_counter, 32'h8);
    @(negedge clock);
    check32("full_br_recapture", 32'(imem_request), 32'h0);
    stall = 1'b0;
    drain("full_branch");

    // Branch penalty and address wrap at the top of memory.
    reset_dut(0);
    push_run(32'h0, 2);
    push_run(32'hFFFF_FFF8, 4);
    reset = 1'b1; mon_on = 1'b1;
    wait_pc(32'h4, "wrap_arm");
    branch_enable = 1'b1; branch_target = 32'hFFFF_FFF8;
    @(negedge clock);
    branch_enable = 1'b0;
    check32("br_bubble", 32'(if_valid), 32'h0);
    @(negedge clock);
    check32("br_penalty_valid", 32'(if_valid), 32'h1);
    check32("br_penalty_pc", if_program_counter, 32'hFFFF_FFF8);
    drain("wrap");

    // Reset while a request is outstanding.
    reset_dut(2);
    push_run(32'h0, 2);
    reset = 1'b1; mon_on = 1'b1;
    wait_req(32'h8, "midrst_arm");
    reset = 1'b0;
    @(negedge clock);
    check32("midrst_request", 32'(imem_request), 32'h0);
    check32("midrst_valid", 32'(if_valid), 32'h0);
    check32("midrst_address", imem_address, RESET_VECTOR);
    check32("midrst_prior", exp_q.size(), 32'h0);
    push_run(32'h0, 3);
    reset = 1'b1;
    drain("midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the pipelined MIPS CPU: owns the fetch program counter, drives a request/ready handshake to instruction memory, and presents each fetched instruction and its address to the IF/ID pipeline register. It handles pipeline stalls with a one-entry holding register and redirects on taken branches and jumps, discarding any in-flight fetch. It is the producer side of the IF→ID interface.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- NOP_WORD, 32'h0000_0000, instruction value presented when no valid instruction is available
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset (sampled on posedge clock; 0 = reset)
- stall  input  1  downstream cannot accept; hold outputs
- branch_enable  input  1  one-cycle redirect pulse from ID
- branch_target  input  `INST_ADDR_BUS  redirect address; bits [1:0] forced to 0
- imem_request  output  1  fetch request to instruction memory
- imem_address  output  `INST_ADDR_BUS  fetch address, word-aligned
- imem_ready  input  1  memory returns imem_data this cycle
- imem_data  input  `INST_DATA_BUS  fetched instruction word
- if_program_counter  output  `INST_ADDR_BUS  address of the presented instruction
- if_instruction  output  `INST_DATA_BUS  presented instruction
- if_valid  output  1  if_instruction is a real, non-squashed instruction

## Operation
- Reset (reset==0 at posedge): state IDLE; fetch_pc = RESET_VECTOR; imem_request=0; imem_address=RESET_VECTOR; if_program_counter=0; if_instruction=NOP_WORD; if_valid=0; skid register empty.
- States: IDLE (no request outstanding), WAIT (request outstanding), FULL (skid holds fetched word, request dropped), FLUSH (outstanding request whose data must be discarded).
- IDLE: if !stall, raise imem_request with imem_address=fetch_pc and go to WAIT; otherwise remain in IDLE.
- WAIT, imem_ready=0: hold request. A branch sets fetch_pc=target and moves to FLUSH.
- WAIT, imem_ready=1, no branch, !stall:
  - Outputs take (imem_address, imem_data) with if_valid=1.
  - fetch_pc += 4; the next request goes out at the new address; stay in WAIT.
- WAIT, imem_ready=1, stall: capture the word into the skid register, drop imem_request, go to FULL.
- WAIT, imem_ready=1, branch: discard the data, request branch_target, stay in WAIT.
- FLUSH: hold request at the old address. On imem_ready, discard the data, request fetch_pc (the branch target), go to WAIT. A second branch while in FLUSH overwrites fetch_pc.
- FULL: while stall, hold. On stall falling, outputs take the skid word with if_valid=1, skid clears, request fetch_pc+4, go to WAIT. A branch clears the skid, requests the target, and goes to WAIT.
- Bubbles: in any cycle with !stall and no delivery, outputs update to if_valid=0 and if_instruction=NOP_WORD; if_program_counter keeps its last value.
- Any branch cycle with !stall also forces this bubble. branch_enable takes priority over stall.
- Address arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Handshake: imem_request and imem_address are registered and stay stable until the cycle in which imem_ready is sampled high. imem_ready may be asserted in the same cycle the request first appears.
- Latency: the word returned on an imem_ready cycle appears on if_* at the next posedge.
- Throughput: with imem_ready tied high, one instruction per cycle.
- Reset-to-request: imem_request is first high at the 2nd posedge after reset releases (IDLE, then WAIT).
- Branch penalty, zero-wait memory: the target instruction is valid on if_* 2 cycles after the branch_enable cycle.
- Stall: if_* hold unchanged during every stall cycle, including the first one.
- Reset mid-operation: reset overrides all states. The pending memory response is ignored, because imem_request is dropped the same cycle.

## Structure
- Shared constants go in utility/utility.v:
  - `INST_ADDR_BUS and `INST_DATA_BUS
  - `ENABLE/`DISABLE
  - a new `INST_ADDR_STEP (4)
  - fetch state encodings (`FETCH_IDLE, `FETCH_WAIT, `FETCH_FULL, `FETCH_FLUSH; 2 bits)
- One sub-module: fetch_skid_register, a one-entry holding register for address and word with load, clear and valid. The FSM, PC and output registers stay in instruction_fetch.

## Test plan
- Reset then ready tied high: if_valid rises 3 cycles after release; PCs 0x0, 0x4, 0x8, … with the matching imem_data, one per cycle.
- Memory with 2 wait cycles: imem_address holds 0x4 for 3 cycles; exactly one if_valid per fetch; no duplicates.
- Stall asserted on a delivery cycle for 3 cycles: if_* frozen at PC 0x8; the word fetched during the stall is presented as PC 0xC on release, then 0x10.
- branch_enable with target 0x100 while a request at 0x20 is waiting: the data for 0x20 is discarded; the next request is 0x100; the next valid output is PC 0x100.
- Branch with target 0x203 simultaneous with stall in FULL: skid cleared; request 0x200; after stall falls, if_program_counter=0x200.
- Reset asserted in WAIT: the next cycle shows imem_request=0 and if_valid=0; fetch restarts at RESET_VECTOR.
